// File: rtl/m3_commutation_sequencer.sv
// Three-phase six-step commutation sequencer: frequency ramp, phase accumulator,
// PWM on the high side, dead-time blanking on every step change and a timed brake.
module m3_commutation_sequencer #(
  parameter int unsigned RAMP_DIV    = 1000,
  parameter int unsigned STEP_THRESH = 166667,
  parameter int unsigned DEAD_CYC    = 4,
  parameter int unsigned BRAKE_CYC   = 10000
) (
  input  logic       clkI,
  input  logic       rstI,
  input  logic       m3startI,
  input  logic       m3forceStopI,
  input  logic       m3invRotateI,
  input  logic [9:0] freqSetI,
  input  logic [7:0] powerSetI,
  output logic [1:0] aCmdO,
  output logic [1:0] bCmdO,
  output logic [1:0] cCmdO,
  output logic [1:0] stateO,
  output logic [2:0] stepO,
  output logic [9:0] curFreqO
);

  localparam int unsigned RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned BW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  localparam int unsigned KW = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;
  localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_DIV - 1);
  localparam logic [KW-1:0] BRAKE_LAST = KW'(BRAKE_CYC - 1);
  localparam logic [BW-1:0] DEAD       = BW'(DEAD_CYC);
  localparam logic [18:0]   THRESH     = 19'(STEP_THRESH);

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, RUN = 2'd2, BRAKE = 2'd3} state_e;

  state_e          state_q, state_d;
  logic            dir_q, dir_d;
  logic [9:0]      cur_q, cur_d;
  logic [17:0]     acc_q, acc_d;
  logic [2:0]      step_q, step_d;
  logic [7:0]      pwm_q, pwm_d;
  logic [7:0]      lat_q, lat_d;
  logic [RW-1:0]   ramp_q, ramp_d;
  logic [BW-1:0]   blank_q, blank_d;
  logic [KW-1:0]   brake_q, brake_d;
  logic [2:0][1:0] cmd_q, cmd_d;

  logic [9:0]  tgt;
  logic [18:0] sum;
  logic        step_adv;
  logic [1:0]  hi_ph, lo_ph;

  // Next-state, datapath and phase command computation
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cur_d    = cur_q;
    acc_d    = acc_q;
    step_d   = step_q;
    ramp_d   = ramp_q;
    brake_d  = brake_q;
    pwm_d    = pwm_q + 8'd1;
    lat_d    = (pwm_q == 8'hFF) ? powerSetI : lat_q;
    blank_d  = (blank_q != '0) ? blank_q - BW'(1) : '0;
    tgt      = m3startI ? ((freqSetI > 10'd1000) ? 10'd1000 : freqSetI) : 10'd0;
    sum      = 19'(acc_q) + 19'(cur_q);
    step_adv = 1'b0;
    hi_ph    = 2'd0;
    lo_ph    = 2'd1;
    cmd_d    = '0;

    case (state_q)
      IDLE: begin
        dir_d = m3invRotateI;
        if (tgt != 10'd0 && !m3forceStopI) begin
          state_d = RAMP;
          ramp_d  = '0;
        end
      end
      RAMP, RUN: begin
        step_adv = (sum >= THRESH);
        acc_d    = step_adv ? 18'(sum - THRESH) : 18'(sum);
        if (step_adv) begin
          if (dir_q) step_d = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;
          else       step_d = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
          blank_d = DEAD;
        end
        if (state_q == RAMP) begin
          if (ramp_q == RAMP_LAST) begin
            ramp_d = '0;
            if (cur_q < tgt)      cur_d = cur_q + 10'd1;
            else if (cur_q > tgt) cur_d = cur_q - 10'd1;
          end else begin
            ramp_d = ramp_q + RW'(1);
          end
          if (cur_q == tgt && tgt != 10'd0)        state_d = RUN;
          else if (cur_q == 10'd0 && tgt == 10'd0) state_d = IDLE;
        end else if (tgt != cur_q) begin
          state_d = RAMP;
          ramp_d  = '0;
        end
        if (m3forceStopI) begin
          state_d = BRAKE;
          brake_d = '0;
          step_d  = step_q;
        end
      end
      default: begin
        if (brake_q == BRAKE_LAST) begin
          if (!m3forceStopI) state_d = IDLE;
        end else begin
          brake_d = brake_q + KW'(1);
        end
      end
    endcase

    // Speed and phase position are discarded whenever the motor is not being driven
    if (state_d == IDLE || state_d == BRAKE) begin
      cur_d   = '0;
      acc_d   = '0;
      blank_d = '0;
    end
    if (state_d == IDLE) step_d = 3'd0;

    case (step_d)
      3'd0:    begin hi_ph = 2'd0; lo_ph = 2'd1; end
      3'd1:    begin hi_ph = 2'd0; lo_ph = 2'd2; end
      3'd2:    begin hi_ph = 2'd1; lo_ph = 2'd2; end
      3'd3:    begin hi_ph = 2'd1; lo_ph = 2'd0; end
      3'd4:    begin hi_ph = 2'd2; lo_ph = 2'd0; end
      default: begin hi_ph = 2'd2; lo_ph = 2'd1; end
    endcase

    case (state_d)
      RAMP, RUN: begin
        if (blank_d == '0) begin
          for (int p = 0; p < 3; p++) begin
            if (2'(p) == hi_ph)      cmd_d[p] = (pwm_d < lat_d) ? 2'd2 : 2'd0;
            else if (2'(p) == lo_ph) cmd_d[p] = 2'd1;
          end
        end
      end
      // A phase that was high passes through off before its low side closes
      BRAKE: begin
        for (int p = 0; p < 3; p++) cmd_d[p] = (cmd_q[p] == 2'd2) ? 2'd0 : 2'd1;
      end
      default: cmd_d = '0;
    endcase
  end

  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      cur_q   <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      pwm_q   <= '0;
      lat_q   <= '0;
      ramp_q  <= '0;
      blank_q <= '0;
      brake_q <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cur_q   <= cur_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      pwm_q   <= pwm_d;
      lat_q   <= lat_d;
      ramp_q  <= ramp_d;
      blank_q <= blank_d;
      brake_q <= brake_d;
      cmd_q   <= cmd_d;
    end
  end

  assign aCmdO    = cmd_q[0];
  assign bCmdO    = cmd_q[1];
  assign cCmdO    = cmd_q[2];
  assign stateO   = state_q;
  assign stepO    = step_q;
  assign curFreqO = cur_q;

endmodule

// File: tb/tb_m3_commutation_sequencer.sv
// Bench for m3_commutation_sequencer: directed vector table, reset sequence and
// randomized traffic against a cycle-level behavioural model.
module tb_m3_commutation_sequencer;

  localparam int RD = 4;
  localparam int TH = 100;
  localparam int DC = 2;
  localparam int BC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, force_stop = 1'b0, inv = 1'b0;
  logic [9:0] freq = '0;
  logic [7:0] pow = '0;
  logic [1:0] a_cmd, b_cmd, c_cmd, state_o;
  logic [2:0] step_o;
  logic [9:0] cur_o;

  always #5 clk = ~clk;

  m3_commutation_sequencer #(
    .RAMP_DIV(RD), .STEP_THRESH(TH), .DEAD_CYC(DC), .BRAKE_CYC(BC)
  ) dut (
    .clkI(clk), .rstI(rst), .m3startI(start), .m3forceStopI(force_stop),
    .m3invRotateI(inv), .freqSetI(freq), .powerSetI(pow),
    .aCmdO(a_cmd), .bCmdO(b_cmd), .cCmdO(c_cmd),
    .stateO(state_o), .stepO(step_o), .curFreqO(cur_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase position as a running sum, blanking as "cycles since last step"
  int hi_tab[6] = '{0, 0, 1, 1, 2, 2};
  int lo_tab[6] = '{1, 2, 2, 0, 0, 1};
  int m_state, m_dir, m_cur, m_acc, m_step, m_pwm, m_lat, m_rage, m_bage, m_since;
  int m_cmd[3];
  int prev_dut[3];

  task automatic m_reset();
    m_state = 0; m_dir = 0; m_cur = 0; m_acc = 0; m_step = 0;
    m_pwm = 0; m_lat = 0; m_rage = 0; m_bage = 0; m_since = DC;
    for (int p = 0; p < 3; p++) begin m_cmd[p] = 0; prev_dut[p] = 0; end
  endtask

  task automatic m_clock(input int s, input int f, input int iv, input int fr, input int pw);
    int tgt, total, old;
    tgt = s ? ((fr > 1000) ? 1000 : fr) : 0;
    if (m_pwm == 255) m_lat = pw;
    m_pwm = (m_pwm + 1) % 256;
    m_since = (m_since < DC) ? m_since + 1 : DC;
    case (m_state)
      0: begin
        m_dir = iv;
        if (tgt != 0 && f == 0) begin m_state = 1; m_rage = 0; end
      end
      1, 2: begin
        if (f != 0) begin
          m_state = 3; m_bage = 0;
        end else begin
          total = m_acc + m_cur;
          if (total >= TH) begin
            m_step  = (m_step + (m_dir ? 5 : 1)) % 6;
            m_since = 0;
          end
          m_acc = total % TH;
          if (m_state == 1) begin
            old = m_cur;
            if ((m_rage % RD) == RD - 1 && old != tgt) m_cur = (tgt > old) ? old + 1 : old - 1;
            m_rage++;
            if (old == tgt && tgt != 0)    m_state = 2;
            else if (old == 0 && tgt == 0) m_state = 0;
          end else if (tgt != m_cur) begin
            m_state = 1; m_rage = 0;
          end
        end
      end
      default: begin
        if (m_bage + 1 >= BC && f == 0) m_state = 0;
        else m_bage++;
      end
    endcase
    if (m_state == 0 || m_state == 3) begin m_cur = 0; m_acc = 0; m_since = DC; end
    if (m_state == 0) m_step = 0;
    for (int p = 0; p < 3; p++) begin
      if (m_state == 0)         m_cmd[p] = 0;
      else if (m_state == 3)    m_cmd[p] = (m_cmd[p] == 2) ? 0 : 1;
      else if (m_since < DC)    m_cmd[p] = 0;
      else if (p == hi_tab[m_step]) m_cmd[p] = (m_pwm < m_lat) ? 2 : 0;
      else if (p == lo_tab[m_step]) m_cmd[p] = 1;
      else                      m_cmd[p] = 0;
    end
  endtask

  task automatic compare_all();
    int d[3];
    d[0] = int'(a_cmd); d[1] = int'(b_cmd); d[2] = int'(c_cmd);
    check("state", int'(state_o), m_state);
    check("step", int'(step_o), m_step);
    check("curFreq", int'(cur_o), m_cur);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("cmd%0d", p), d[p], m_cmd[p]);
      check($sformatf("cmd%0d_not3", p), (d[p] != 3) ? 1 : 0, 1);
      check($sformatf("cmd%0d_no_direct_swap", p),
            ((prev_dut[p] == 2 && d[p] == 1) || (prev_dut[p] == 1 && d[p] == 2)) ? 0 : 1, 1);
      prev_dut[p] = d[p];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock(int'(start), int'(force_stop), int'(inv), int'(freq), int'(pow));
    #1;
    compare_all();
  endtask

  typedef struct {
    logic s, f, i;
    int   fr, pw, n;
    int   st, sp, cu;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic f, input logic i, input int fr,
                              input int pw, input int n, input int st, input int sp, input int cu);
    vec_t v;
    v.s = s; v.f = f; v.i = i; v.fr = fr; v.pw = pw; v.n = n; v.st = st; v.sp = sp; v.cu = cu;
    return v;
  endfunction

  vec_t tbl[28];

  initial begin
    // start, force, inv, freq, power, cycles -> state, step, curFreq after the last cycle
    tbl[0]  = mk(1, 0, 0,    5,  64,  1, 1, 0, 0);
    tbl[1]  = mk(1, 0, 0,    5,  64,  4, 1, 0, 1);
    tbl[2]  = mk(1, 0, 0,    5,  64, 16, 1, 0, 5);
    tbl[3]  = mk(1, 0, 0,    5,  64,  1, 2, 0, 5);
    tbl[4]  = mk(1, 0, 0,    5,  64, 11, 2, 1, 5);
    tbl[5]  = mk(1, 0, 0,    5,  64, 20, 2, 2, 5);
    tbl[6]  = mk(1, 0, 0,    5,  64, 60, 2, 5, 5);
    tbl[7]  = mk(1, 0, 1,    5, 100, 20, 2, 0, 5);
    tbl[8]  = mk(0, 0, 1,    5, 100,  1, 1, 0, 5);
    tbl[9]  = mk(0, 0, 1,    5, 100,  4, 1, 0, 4);
    tbl[10] = mk(0, 0, 1,    5, 100, 16, 1, 0, 0);
    tbl[11] = mk(0, 0, 1,    5, 100,  1, 0, 0, 0);
    tbl[12] = mk(1, 0, 1,    5,  64,  1, 1, 0, 0);
    tbl[13] = mk(1, 0, 1,    5,  64, 20, 1, 0, 5);
    tbl[14] = mk(1, 0, 1,    5,  64,  1, 2, 0, 5);
    tbl[15] = mk(1, 0, 1,    5,  64, 11, 2, 5, 5);
    tbl[16] = mk(1, 0, 0,    5,  64, 20, 2, 4, 5);
    tbl[17] = mk(1, 0, 0, 1023,  64,  1, 1, 4, 5);
    tbl[18] = mk(1, 0, 0, 1023,  64,  4, 1, 4, 6);
    tbl[19] = mk(1, 1, 0, 1023,  64,  1, 3, 4, 0);
    tbl[20] = mk(1, 1, 0, 1023,  64,  1, 3, 4, 0);
    tbl[21] = mk(1, 0, 0, 1023,  64,  6, 3, 4, 0);
    tbl[22] = mk(0, 0, 0, 1023,  64,  1, 0, 0, 0);
    tbl[23] = mk(1, 0, 0,    5,  64,  1, 1, 0, 0);
    tbl[24] = mk(1, 1, 0,    5,  64,  1, 3, 0, 0);
    tbl[25] = mk(1, 1, 0,    5,  64, 20, 3, 0, 0);
    tbl[26] = mk(0, 0, 0,    5,  64,  1, 0, 0, 0);
    tbl[27] = mk(0, 0, 0,    5,  64,  2, 0, 0, 0);

    m_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", int'(state_o), 0);
    check("reset_step", int'(step_o), 0);
    check("reset_cur", int'(cur_o), 0);
    check("reset_cmds", int'({a_cmd, b_cmd, c_cmd}), 0);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      start = tbl[i].s; force_stop = tbl[i].f; inv = tbl[i].i;
      freq = 10'(tbl[i].fr); pow = 8'(tbl[i].pw);
      for (int k = 0; k < tbl[i].n; k++) tick();
      check($sformatf("row%0d_state", i), int'(state_o), tbl[i].st);
      check($sformatf("row%0d_step", i), int'(step_o), tbl[i].sp);
      check($sformatf("row%0d_cur", i), int'(cur_o), tbl[i].cu);
    end

    // Asynchronous reset in the middle of RUN, then restart from IDLE
    start = 1'b1; force_stop = 1'b0; inv = 1'b0; freq = 10'd5; pow = 8'd200;
    repeat (40) tick();
    check("pre_reset_state", int'(state_o), 2);
    check("pre_reset_step", int'(step_o), 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_state", int'(state_o), 0);
    check("async_reset_step", int'(step_o), 0);
    check("async_reset_cur", int'(cur_o), 0);
    check("async_reset_cmds", int'({a_cmd, b_cmd, c_cmd}), 0);
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check("post_reset_state", int'(state_o), 1);

    // Randomized traffic
    for (int burst = 0; burst < 150; burst++) begin
      start      = ($urandom_range(0, 7) != 0);
      force_stop = ($urandom_range(0, 19) == 0);
      inv        = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       freq = 10'd0;
        1:       freq = 10'($urandom_range(995, 1023));
        default: freq = 10'($urandom_range(1, 40));
      endcase
      pow = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 40)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m3_commutation_sequencer.md
M3_COMMUTATION_SEQUENCER -- requirements
Module: m3_commutation_sequencer

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 1000: clock cycles per 1-unit frequency ramp step.
REQ-002 SHALL have parameter STEP_THRESH, default 166667: phase-accumulator threshold for one commutation step, equal to 1e6/6 at a 1 MHz clock.
REQ-003 SHALL have parameter DEAD_CYC, default 4: cycles all phases are forced off after each step change.
REQ-004 SHALL have parameter BRAKE_CYC, default 10000: minimum brake duration in cycles.
REQ-005 SHALL have port clkI, input, 1 bit: single clock, 1 MHz.
REQ-006 SHALL have port rstI, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port m3startI, input, 1 bit: run request, level-sensitive.
REQ-008 SHALL have port m3forceStopI, input, 1 bit: emergency brake request.
REQ-009 SHALL have port m3invRotateI, input, 1 bit: direction request; 1 = reverse.
REQ-010 SHALL have port freqSetI, input, 10 bits: target electrical frequency in Hz.
REQ-011 SHALL have port powerSetI, input, 8 bits: PWM duty target.
REQ-012 SHALL have ports aCmdO, bCmdO and cCmdO, output, 2 bits each: per-phase driver command (down1_up2 encoding); 0 = both off, 1 = low side on, 2 = high side on, 3 = never driven.
REQ-013 SHALL have port stateO, output, 2 bits: current state.
REQ-014 SHALL have port stepO, output, 3 bits: current commutation step, 0..5.
REQ-015 SHALL have port curFreqO, output, 10 bits: current ramped frequency.

Function
REQ-016 SHALL implement the states IDLE=0, RAMP=1, RUN=2 and BRAKE=3.
REQ-017 SHALL compute effective target tgt = m3startI ? min(freqSetI,1000) : 0.
REQ-018 SHALL, in IDLE:
- drive all cmds 0 and hold curFreq=0, acc=0, step=0;
- latch dir=m3invRotateI every cycle;
- go to RAMP when tgt!=0 and m3forceStopI=0.
REQ-019 SHALL keep dir frozen outside IDLE; direction changes take effect only after returning to IDLE.
REQ-020 SHALL, in RAMP, move curFreq by +/-1 toward tgt once every RAMP_DIV cycles, using a free-running ramp divider that is cleared on entry to RAMP.
REQ-021 SHALL, in RAMP, go to RUN when curFreq==tgt!=0, and go to IDLE when curFreq==0 and tgt==0.
REQ-022 SHALL, in RUN, return to RAMP in the cycle after tgt!=curFreq is detected.
REQ-023 SHALL run an 18-bit accumulator acc in RAMP/RUN:
- each cycle, if acc+curFreq >= STEP_THRESH, set acc = acc+curFreq-STEP_THRESH and advance step;
- otherwise set acc = acc+curFreq.
REQ-024 SHALL advance step mod 6: +1 when dir=0 (5->0 wrap), -1 when dir=1 (0->5 wrap).
REQ-025 SHALL use the commutation table (high, low, float):
- step 0: A, B, C;
- step 1: A, C, B;
- step 2: B, C, A;
- step 3: B, A, C;
- step 4: C, A, B;
- step 5: C, B, A.
REQ-026 SHALL drive the float phase 0 and the low phase 1, and drive the high phase 2 when pwmCnt<pwrLat, else 0.
REQ-027 SHALL use a free-running 8-bit counter pwmCnt (wraps 255->0) and load pwrLat from powerSetI only when pwmCnt==255, so a duty change never truncates a PWM period.
REQ-028 SHALL force all cmds to 0 for DEAD_CYC cycles starting the cycle after any step change; a further step change during blanking restarts the blanking count.
REQ-029 SHALL enter BRAKE from RAMP/RUN in the cycle after m3forceStopI=1 is sampled; forceStop has priority over every other transition.
REQ-030 SHALL, in BRAKE, drive all cmds 1 (all low sides on), clear curFreq and acc, and count BRAKE_CYC cycles; it SHALL exit to IDLE only after the count has expired and m3forceStopI=0.
REQ-031 SHALL register all outputs; cmds SHALL never be 3, and no phase may change 2->1 or 1->2 without at least one 0 cycle.
REQ-032 SHALL hold state when freqSetI>1000 is clamped to 1000 (no error condition).

Reset
REQ-033 SHALL, while rstI=1, force state=IDLE and all of the following to 0: cmds, stepO, curFreqO, acc, pwmCnt, pwrLat, ramp divider, blank counter, brake counter and dir.
REQ-034 SHALL have reset asserted mid-RUN force all cmds to 0 asynchronously, and operation SHALL resume from IDLE on the first clkI edge after release.

Verification (RAMP_DIV=4, STEP_THRESH=100, DEAD_CYC=2, BRAKE_CYC=8)
REQ-035 SHALL cover ramp-up: start=1, freqSet=5 -> curFreq 1,2,3,4,5 at 4-cycle intervals, then stateO=2; steps advance every 20 cycles in RUN.
REQ-036 SHALL cover commutation/direction: dir=0, step 5 -> 0 wraps; dir=1 -> 0 -> 5; invRotate toggled in RUN leaves the sequence unchanged until IDLE.
REQ-037 SHALL cover PWM and dead time: powerSet=64 -> high phase is 2 for exactly 64 of 256 cycles; all cmds are 0 for 2 cycles after each step change; a powerSet change mid-period is applied only after pwmCnt wraps.
REQ-038 SHALL cover brake: forceStop=1 in RUN -> next cycle all cmds=1, stateO=3; release at cycle 3 -> IDLE after cycle 8; if held, remain in BRAKE.
REQ-039 SHALL cover stop ramp: start=0 at curFreq=5 -> decrement to 0 over 20 cycles, then IDLE with all cmds 0.
REQ-040 SHALL cover reset: rstI pulsed mid-RUN -> all outputs 0 immediately, stateO=0, stepO=0.
